// File: rtl/single_cycle_mips_cpu.sv
// single_cycle_mips_cpu: 32-bit single-cycle MIPS-subset processor.
// Contains the PC, a fixed 32-word instruction ROM, a 32x32 register file
// (DEC5T32E write decoder, 32 registers, two MUX32X32 read muxes), an ALU
// built around ADDSUB_32, a 32-word data RAM and the control decoder.
// Ports:
//   Clk      - clock; all state changes on the rising edge
//   Reset    - asynchronous active-low; clears PC and registers (not RAM)
//   Addr     - current PC          Inst  - instruction at PC
//   Qa / Qb  - register reads (rs / rt)
//   ALU_R    - ALU result          NEXTADDR - next PC
//   D        - register write-back data

// ADDSUB_32: r = x + y (sub=0) or x + ~y + 1 (sub=1), wrap-around.
module ADDSUB_32 (
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   input  logic        sub_i,
   output logic [31:0] r_o
);
   assign r_o = x_i + (y_i ^ {32{sub_i}}) + {31'b0, sub_i};
endmodule

// DEC5T32E: one-hot decode of wr_i, all zeros when we_i is low.
module DEC5T32E (
   input  logic [4:0]  wr_i,
   input  logic        we_i,
   output logic [31:0] dec_o
);
   always_comb begin
      dec_o = '0;
      if (we_i) dec_o[wr_i] = 1'b1;
   end
endmodule

// MUX32X32: selects one of 32 words.
module MUX32X32 (
   input  logic [31:0][31:0] d_i,
   input  logic [4:0]        s_i,
   output logic [31:0]       y_o
);
   assign y_o = d_i[s_i];
endmodule

module single_cycle_mips_cpu (
   input  logic        Clk,
   input  logic        Reset,
   output logic [31:0] Addr,
   output logic [31:0] Inst,
   output logic [31:0] Qa,
   output logic [31:0] Qb,
   output logic [31:0] ALU_R,
   output logic [31:0] NEXTADDR,
   output logic [31:0] D
);
   logic [31:0] pc_q, pc4, alu_sum, imm, alu_b, ram_rd;
   logic [31:0] regs_q [32];
   logic [31:0][31:0] regs_flat;
   logic [31:0] wdec;
   logic [31:0] ram_q [32] = '{default: '0};  // power-up contents only
   logic [5:0]  op, funct;
   logic [4:0]  wr;
   logic [1:0]  aluc;
   logic        wreg, wmem, m2reg, regrt, sext, aluimm, is_beq, is_bne, is_j, zero;

   // Instruction ROM
   always_comb begin
      case (pc_q[6:2])
         5'h00:   Inst = 32'h2001_0008;
         5'h01:   Inst = 32'h3402_000C;
         5'h02:   Inst = 32'h0022_1820;
         5'h03:   Inst = 32'h0041_2022;
         5'h04:   Inst = 32'h0022_2824;
         5'h05:   Inst = 32'h0022_3025;
         5'h06:   Inst = 32'h1422_0002;
         5'h09:   Inst = 32'h1022_0002;
         5'h0A:   Inst = 32'h0800_000D;
         5'h0D:   Inst = 32'hAD02_000A;
         5'h0E:   Inst = 32'h8D04_000A;
         5'h0F:   Inst = 32'h1044_0003;
         5'h13:   Inst = 32'h3047_0009;
         default: Inst = 32'h0000_0000;
      endcase
   end

   assign op    = Inst[31:26];
   assign funct = Inst[5:0];

   // Control decode; unrecognised encodings leave every enable low.
   always_comb begin
      wreg = 1'b0; wmem = 1'b0; m2reg = 1'b0; regrt = 1'b0; sext = 1'b0;
      aluimm = 1'b0; aluc = 2'b00; is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h20: wreg = 1'b1;
               6'h22: begin wreg = 1'b1; aluc = 2'b01; end
               6'h24: begin wreg = 1'b1; aluc = 2'b10; end
               6'h25: begin wreg = 1'b1; aluc = 2'b11; end
               default: ;
            endcase
         end
         6'h08: begin wreg = 1'b1; regrt = 1'b1; sext = 1'b1; aluimm = 1'b1; end
         6'h0C: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = 2'b10; end
         6'h0D: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = 2'b11; end
         6'h23: begin
            wreg = 1'b1; regrt = 1'b1; sext = 1'b1; aluimm = 1'b1; m2reg = 1'b1;
         end
         6'h2B: begin wmem = 1'b1; sext = 1'b1; aluimm = 1'b1; end
         6'h04: begin is_beq = 1'b1; sext = 1'b1; aluc = 2'b01; end
         6'h05: begin is_bne = 1'b1; sext = 1'b1; aluc = 2'b01; end
         6'h02: is_j = 1'b1;
         default: ;
      endcase
   end

   assign wr  = regrt ? Inst[20:16] : Inst[15:11];
   assign imm = sext ? {{16{Inst[15]}}, Inst[15:0]} : {16'h0000, Inst[15:0]};

   // Register file
   DEC5T32E u_dec (.wr_i(wr), .we_i(wreg), .dec_o(wdec));

   // Register 0 is cleared by reset and never loaded, so it always reads 0.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (wdec[i] && (i != 0)) regs_q[i] <= D;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 32; i++) regs_flat[i] = regs_q[i];
   end

   MUX32X32 u_mux_a (.d_i(regs_flat), .s_i(Inst[25:21]), .y_o(Qa));
   MUX32X32 u_mux_b (.d_i(regs_flat), .s_i(Inst[20:16]), .y_o(Qb));

   // ALU
   assign alu_b = aluimm ? imm : Qb;
   ADDSUB_32 u_alu_as (.x_i(Qa), .y_i(alu_b), .sub_i(aluc == 2'b01), .r_o(alu_sum));

   always_comb begin
      case (aluc)
         2'b10:   ALU_R = Qa & alu_b;
         2'b11:   ALU_R = Qa | alu_b;
         default: ALU_R = alu_sum;
      endcase
   end

   assign zero = (ALU_R == 32'h0);

   // Data RAM
   assign ram_rd = ram_q[ALU_R[6:2]];
   always_ff @(posedge Clk) begin
      if (wmem) ram_q[ALU_R[6:2]] <= Qb;
   end

   assign D = m2reg ? ram_rd : ALU_R;

   // Next PC
   ADDSUB_32 u_pc4 (.x_i(pc_q), .y_i(32'd4), .sub_i(1'b0), .r_o(pc4));

   always_comb begin
      if ((is_beq && zero) || (is_bne && !zero)) begin
         NEXTADDR = pc4 + {{14{Inst[15]}}, Inst[15:0], 2'b00};
      end else if (is_j) begin
         NEXTADDR = {pc4[31:28], Inst[25:0], 2'b00};
      end else begin
         NEXTADDR = pc4;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) pc_q <= '0;
      else        pc_q <= NEXTADDR;
   end

   assign Addr = pc_q;
endmodule

// File: tb/tb_single_cycle_mips_cpu.sv
// Self-checking bench for single_cycle_mips_cpu: a behavioural ISA model runs
// alongside the CPU, reset is asserted at random points, and the adder,
// decoder and mux blocks are exercised on their own.
module tb_single_cycle_mips_cpu;
   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] Addr, Inst, Qa, Qb, ALU_R, NEXTADDR, D;

   logic [31:0] as_x, as_y, as_r;
   logic        as_sub;
   logic [4:0]  dec_wr, mux_s;
   logic        dec_we;
   logic [31:0] dec_o, mux_y;
   logic [31:0][31:0] mux_d;

   always #5 Clk = ~Clk;

   single_cycle_mips_cpu dut (
      .Clk(Clk), .Reset(Reset), .Addr(Addr), .Inst(Inst), .Qa(Qa), .Qb(Qb),
      .ALU_R(ALU_R), .NEXTADDR(NEXTADDR), .D(D)
   );
   ADDSUB_32 u_as  (.x_i(as_x), .y_i(as_y), .sub_i(as_sub), .r_o(as_r));
   DEC5T32E  u_dec (.wr_i(dec_wr), .we_i(dec_we), .dec_o(dec_o));
   MUX32X32  u_mux (.d_i(mux_d), .s_i(mux_s), .y_o(mux_y));

   int errors = 0;
   int checks = 0;

   logic [31:0] rom [32];
   logic [31:0] m_regs [32];
   logic [31:0] m_ram [32];
   logic [31:0] m_pc;
   logic [31:0] e_inst, e_qa, e_qb, e_alu, e_next, e_d;
   logic [4:0]  e_wr;
   bit          e_valid, e_we, e_mw;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural meaning of the instruction at m_pc.
   task automatic model_eval();
      logic [31:0] simm, zimm, pc4;
      logic [5:0]  op, fn;
      e_inst = rom[m_pc[6:2]];
      op   = e_inst[31:26];
      fn   = e_inst[5:0];
      e_qa = m_regs[e_inst[25:21]];
      e_qb = m_regs[e_inst[20:16]];
      simm = 32'($signed(e_inst[15:0]));
      zimm = {16'h0000, e_inst[15:0]};
      pc4  = m_pc + 32'd4;
      e_next = pc4; e_valid = 1'b0; e_we = 1'b0; e_mw = 1'b0; e_wr = 5'd0; e_alu = '0;
      if (op == 6'h00 && fn == 6'h20)      begin e_alu = e_qa + e_qb; e_valid = 1; e_we = 1; e_wr = e_inst[15:11]; end
      else if (op == 6'h00 && fn == 6'h22) begin e_alu = e_qa - e_qb; e_valid = 1; e_we = 1; e_wr = e_inst[15:11]; end
      else if (op == 6'h00 && fn == 6'h24) begin e_alu = e_qa & e_qb; e_valid = 1; e_we = 1; e_wr = e_inst[15:11]; end
      else if (op == 6'h00 && fn == 6'h25) begin e_alu = e_qa | e_qb; e_valid = 1; e_we = 1; e_wr = e_inst[15:11]; end
      else if (op == 6'h08) begin e_alu = e_qa + simm; e_valid = 1; e_we = 1; e_wr = e_inst[20:16]; end
      else if (op == 6'h0C) begin e_alu = e_qa & zimm; e_valid = 1; e_we = 1; e_wr = e_inst[20:16]; end
      else if (op == 6'h0D) begin e_alu = e_qa | zimm; e_valid = 1; e_we = 1; e_wr = e_inst[20:16]; end
      else if (op == 6'h23) begin e_alu = e_qa + simm; e_valid = 1; e_we = 1; e_wr = e_inst[20:16]; end
      else if (op == 6'h2B) begin e_alu = e_qa + simm; e_valid = 1; e_mw = 1; end
      else if (op == 6'h04) begin
         e_alu = e_qa - e_qb; e_valid = 1;
         if (e_qa == e_qb) e_next = pc4 + simm * 4;
      end else if (op == 6'h05) begin
         e_alu = e_qa - e_qb; e_valid = 1;
         if (e_qa != e_qb) e_next = pc4 + simm * 4;
      end else if (op == 6'h02) begin
         e_next = {pc4[31:28], e_inst[25:0], 2'b00};
      end
      e_d = (op == 6'h23) ? m_ram[e_alu[6:2]] : e_alu;
   endtask

   task automatic model_commit();
      if (e_we && e_wr != 5'd0) m_regs[e_wr] = e_d;
      if (e_mw) m_ram[e_alu[6:2]] = e_qb;
      m_pc = e_next;
   endtask

   task automatic model_reset();
      m_pc = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   task automatic compare_all();
      model_eval();
      check("Addr", Addr, m_pc);
      check("Inst", Inst, e_inst);
      check("Qa", Qa, e_qa);
      check("Qb", Qb, e_qb);
      check("NEXTADDR", NEXTADDR, e_next);
      if (e_valid) begin
         check("ALU_R", ALU_R, e_alu);
         check("D", D, e_d);
      end
      // Landmarks of the fixed program
      case (m_pc)
         32'h18: check("bne_taken", NEXTADDR, 32'h24);
         32'h24: check("beq_not_taken", NEXTADDR, 32'h28);
         32'h28: check("jump", NEXTADDR, 32'h34);
         32'h34: check("sw_addr", ALU_R, 32'd10);
         32'h38: check("lw_data", D, 32'd12);
         32'h3C: check("beq_taken", NEXTADDR, 32'h4C);
         32'h4C: check("andi", ALU_R, 32'd8);
         default: ;
      endcase
   endtask

   // Check the current cycle, then advance one clock.
   task automatic step();
      compare_all();
      @(posedge Clk);
      if (Reset) model_commit();
      @(negedge Clk);
      #1;
   endtask

   task automatic hit_reset(input int hold);
      Reset = 1'b0;
      #1;
      model_reset();
      check("reset_addr", Addr, 32'h0);
      check("reset_qb", Qb, 32'h0);
      repeat (hold) step();
      Reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin rom[i] = '0; m_ram[i] = '0; end
      rom[5'h00] = 32'h2001_0008; rom[5'h01] = 32'h3402_000C; rom[5'h02] = 32'h0022_1820;
      rom[5'h03] = 32'h0041_2022; rom[5'h04] = 32'h0022_2824; rom[5'h05] = 32'h0022_3025;
      rom[5'h06] = 32'h1422_0002; rom[5'h09] = 32'h1022_0002; rom[5'h0A] = 32'h0800_000D;
      rom[5'h0D] = 32'hAD02_000A; rom[5'h0E] = 32'h8D04_000A; rom[5'h0F] = 32'h1044_0003;
      rom[5'h13] = 32'h3047_0009;
      model_reset();

      // Power-on reset
      #1;
      check("por_addr", Addr, 32'h0);
      check("por_inst", Inst, 32'h2001_0008);
      @(negedge Clk);
      #1;
      Reset = 1'b1;

      // Full program pass, stopping before the PC wraps back into the ROM
      repeat (17) step();

      // Reset at PC 0x14, then rerun
      hit_reset(2);
      repeat (5) step();
      check("pc_before_mid_reset", Addr, 32'h14);
      hit_reset(1);
      repeat (17) step();

      // Random reset points and hold lengths
      repeat (4) begin
         hit_reset($urandom_range(1, 3));
         repeat ($urandom_range(1, 17)) step();
      end
      hit_reset(1);
      repeat (17) step();

      // ADDSUB_32
      as_x = 32'h7FFF_FFFF; as_y = 32'd1; as_sub = 1'b0; #1;
      check("addsub_max_plus1", as_r, 32'h8000_0000);
      as_x = 32'd0; as_y = 32'd1; as_sub = 1'b1; #1;
      check("addsub_0_minus1", as_r, 32'hFFFF_FFFF);
      repeat (16) begin
         as_x = $urandom; as_y = $urandom; as_sub = 1'($urandom_range(0, 1)); #1;
         check("addsub_rand", as_r, as_sub ? as_x - as_y : as_x + as_y);
      end

      // DEC5T32E
      dec_wr = 5'd31; dec_we = 1'b1; #1;
      check("dec_31", dec_o, 32'h8000_0000);
      dec_we = 1'b0; #1;
      check("dec_we0", dec_o, 32'h0);
      repeat (8) begin
         dec_wr = 5'($urandom_range(0, 31)); dec_we = 1'($urandom_range(0, 1)); #1;
         check("dec_rand", dec_o, dec_we ? (32'd1 << dec_wr) : 32'd0);
      end

      // MUX32X32
      for (int i = 0; i < 32; i++) mux_d[i] = $urandom;
      mux_s = 5'd17; #1;
      check("mux_17", mux_y, mux_d[17]);
      repeat (8) begin
         mux_s = 5'($urandom_range(0, 31)); #1;
         check("mux_rand", mux_y, mux_d[mux_s]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
